// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the burst write arbiter.
// master = arbiter, slave = producers/FIFO model.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 140,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wren;
    logic [DATA_W-1:0]         wrdata;
    logic                      wrfull;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        input  req_valid, req_data, wrfull,
        output req_ready, wren, wrdata, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, wrfull,
        input  req_ready, wren, wrdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ producers.
// Optional macro FIFO_WR_ARB_TAG_EN: top ID_W bits of each written beat carry grant_id.
//
// state | meaning
// IDLE  | no owner; pick next valid producer after rr_ptr (1-cycle bubble)
// BURST | grant_id owns the FIFO write port for up to BURST_LEN beats
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 140,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_wr_arbiter_if.master    bus
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]   pick;
    logic              pick_vld;
    logic              valid_g;
    logic [DATA_W-1:0] data_g;
    logic [DATA_W-1:0] data_out;
    logic              accept;
    logic              wren;
    logic              busy;
    logic [DATA_W-1:0] wrdata;
    logic [NUM_REQ-1:0] req_ready;

    // Walk the search order backwards so the last hit is the first index after rr_ptr.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                pick     = ID_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        valid_g = 1'b0;
        data_g  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                valid_g = bus.req_valid[i];
                data_g  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FIFO_WR_ARB_TAG_EN
    assign data_out = {grant_q, data_g[DATA_W-ID_W-1:0]};
`else
    assign data_out = data_g;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        wren       = 1'b0;
        busy       = 1'b0;
        wrdata     = '0;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                busy   = 1'b1;
                accept = valid_g & ~bus.wrfull;
                wren   = accept;
                wrdata = accept ? data_out : '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == ID_W'(i)) begin
                        req_ready[i] = ~bus.wrfull;
                    end
                end
                if (!valid_g) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.wren      = wren;
    assign bus.wrdata    = wrdata;
    assign bus.req_ready = req_ready;
    assign bus.busy      = busy;
    assign bus.grant_id  = grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer beat queues feed the DUT,
// expected FIFO writes are queued in predicted order and popped on each wren.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 140;
    localparam int BL = 4;
    localparam int IW = 2;

    typedef logic [DW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(BL), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    beat_t    prod_q [NR][$];
    beat_t    exp_q [$];
    logic     full_r;
    int       checks = 0;
    int       errors = 0;
    int       wr_cnt = 0;
    logic [31:0] wr_hist = '0;
    logic [31:0] busy_hist = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int id, input int n);
        return {4'(id), 120'h0, 16'(n)};
    endfunction

    function automatic beat_t exp_of(input int id, input beat_t d);
`ifdef FIFO_WR_ARB_TAG_EN
        return {2'(id), d[DW-3:0]};
`else
        return d;
`endif
    endfunction

    task automatic load(input int id, input int base, input int n);
        for (int k = 0; k < n; k++) prod_q[id].push_back(mk(id, base + k));
    endtask

    task automatic expect_beats(input int id, input int base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_of(id, mk(id, base + k)));
    endtask

    task automatic drive();
        bus.wrfull = full_r;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = (prod_q[i].size() > 0);
            bus.req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
        end
    endtask

    task automatic sample();
        wr_hist   = {wr_hist[30:0], bus.wren};
        busy_hist = {busy_hist[30:0], bus.busy};
        chk("wren_while_full", DW'(bus.wren & bus.wrfull), '0);
        if (bus.wrfull) chk("ready_while_full", DW'(bus.req_ready), '0);
        if (bus.wren) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("stray_write", DW'(1), '0);
            else chk("wrdata", bus.wrdata, exp_q.pop_front());
        end else begin
            chk("wrdata_idle", bus.wrdata, '0);
        end
        for (int i = 0; i < NR; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) void'(prod_q[i].pop_front());
    endtask

    task automatic tick();
        drive();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) prod_q[i].delete();
        exp_q.delete();
        full_r = 1'b0;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_hist = '0;
        busy_hist = '0;
    endtask

    int w0;

    initial begin
        full_r = 1'b0;
        drive();
        @(negedge clk);
        // reset state with every producer requesting
        for (int i = 0; i < NR; i++) load(i, 0, 2);
        drive();
        #1;
        chk("rst_wren", DW'(bus.wren), '0);
        chk("rst_busy", DW'(bus.busy), '0);
        chk("rst_grant", DW'(bus.grant_id), '0);
        chk("rst_ready", DW'(bus.req_ready), '0);
        chk("rst_wrdata", bus.wrdata, '0);

        // single producer, 6 beats: burst of 4, bubble, re-grant for 2
        do_reset();
        load(2, 0, 6);
        expect_beats(2, 0, 6);
        w0 = wr_cnt;
        for (int k = 0; k < 8; k++) tick();
        chk("t1_writes", DW'(wr_cnt - w0), DW'(6));
        chk("t1_pattern", DW'(wr_hist[7:0]), DW'(8'b01111011));
        tick();
        chk("t1_left", DW'(exp_q.size()), '0);

        // all producers valid: grants 0,1,2,3,0, 20 writes in 25 cycles
        do_reset();
        load(0, 0, 8);
        for (int i = 1; i < NR; i++) load(i, 0, 4);
        for (int i = 0; i < NR; i++) expect_beats(i, 0, 4);
        expect_beats(0, 4, 4);
        w0 = wr_cnt;
        for (int k = 0; k < 25; k++) tick();
        chk("t2_writes", DW'(wr_cnt - w0), DW'(20));
        chk("t2_pattern", DW'(wr_hist[24:0]), DW'({5{5'b01111}}));
        chk("t2_left", DW'(exp_q.size()), '0);

        // backpressure on beat 2 for 3 cycles
        do_reset();
        load(1, 0, 4);
        expect_beats(1, 0, 4);
        w0 = wr_cnt;
        for (int k = 0; k < 8; k++) begin
            full_r = (k >= 3 && k <= 5);
            tick();
        end
        full_r = 1'b0;
        chk("t3_writes", DW'(wr_cnt - w0), DW'(4));
        chk("t3_pattern", DW'(wr_hist[7:0]), DW'(8'b01100011));
        chk("t3_busy", DW'(busy_hist[7:0]), DW'(8'b01111111));
        tick();
        chk("t3_left", DW'(exp_q.size()), '0);

        // early release by producer 1, grant passes to 3
        do_reset();
        load(1, 0, 2);
        load(3, 0, 3);
        expect_beats(1, 0, 2);
        expect_beats(3, 0, 3);
        w0 = wr_cnt;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 4) chk("t4_grant3", DW'(bus.grant_id), DW'(3));
        end
        chk("t4_writes", DW'(wr_cnt - w0), DW'(5));
        chk("t4_pattern", DW'(wr_hist[7:0]), DW'(8'b01100111));
        chk("t4_left", DW'(exp_q.size()), '0);

        // async reset mid-burst on beat 1
        do_reset();
        load(2, 0, 4);
        expect_beats(2, 0, 1);
        tick();
        tick();
        drive();
        #1;
        chk("t5_pre_wren", DW'(bus.wren), DW'(1));
        chk("t5_pre_grant", DW'(bus.grant_id), DW'(2));
        rst = 1'b1;
        #1;
        chk("t5_rst_wren", DW'(bus.wren), '0);
        chk("t5_rst_busy", DW'(bus.busy), '0);
        chk("t5_rst_ready", DW'(bus.req_ready), '0);
        chk("t5_rst_grant", DW'(bus.grant_id), '0);
        chk("t5_rst_wrdata", bus.wrdata, '0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < NR; i++) load(i, 8, 1);
        for (int i = 0; i < NR; i++) expect_beats(i, 8, 1);
        w0 = wr_cnt;
        tick();
        tick();
        chk("t5_first_grant", DW'(bus.grant_id), '0);
        for (int k = 0; k < 12; k++) tick();
        chk("t5_writes", DW'(wr_cnt - w0), DW'(4));
        chk("t5_left", DW'(exp_q.size()), '0);

        // producer 3 all-zero data (tag lands in top bits when enabled)
        do_reset();
        prod_q[3].push_back('0);
        exp_q.push_back(exp_of(3, '0));
        w0 = wr_cnt;
        for (int k = 0; k < 4; k++) tick();
        chk("t6_writes", DW'(wr_cnt - w0), DW'(1));
        chk("t6_left", DW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin burst arbiter that shares the write side of the 140-bit async FIFO between NUM_REQ producer ports in the write clock domain.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer for a burst of up to BURST_LEN beats, then drives wren/wrdata into the FIFO.
- It honours the FIFO's wrfull flag, so no beat is ever dropped or duplicated.

Parameters:
- NUM_REQ, 4, number of producer ports (2..8).
- DATA_W, 140, beat width; matches FIFO_WIDTH.
- BURST_LEN, 4, maximum beats per grant (1..16).
- ID_W, 2, grant index width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  write-domain clock; the same net as the FIFO wrclk.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_data  in  NUM_REQ*DATA_W  producer i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-producer beat accepted this cycle.
- wren  out  1  to FIFO write enable.
- wrdata  out  DATA_W  to FIFO write data.
- wrfull  in  1  from FIFO write-side full flag.
- grant_id  out  ID_W  index of the current owner; valid while busy=1.
- busy  out  1  1 while in state BURST.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, grant_id=0, rr_ptr=NUM_REQ-1, beat_cnt=0. All outputs are 0 while rst=1: wren=0, req_ready=0, wrdata=0.
- Reset mid-burst aborts the burst immediately. No wren is issued in the cycle rst is asserted.
- FSM state IDLE:
  - If any req_valid bit is set, select the first set index searching rr_ptr+1, rr_ptr+2, ... with modulo-NUM_REQ wrap.
  - Register that index into grant_id, set beat_cnt=0, go to BURST.
  - If no req_valid bit is set, stay in IDLE.
  - No beat is transferred in IDLE: a 1-cycle arbitration bubble per burst.
- FSM state BURST:
  - accept = req_valid[grant_id] & ~wrfull.
  - wren = accept. wrdata = the req_data slice of grant_id. req_ready[grant_id] = ~wrfull. All other req_ready bits are 0.
  - On accept: beat_cnt increments. If beat_cnt==BURST_LEN-1, go to IDLE.
  - If req_valid[grant_id]==0: go to IDLE with no write that cycle (early release).
  - If wrfull=1 with valid high: hold state, beat_cnt unchanged, wren=0.
  - On any exit from BURST: rr_ptr <= grant_id.
- Handshake rules:
  - A beat transfers only when valid & ready are both 1.
  - Producers must hold data stable while valid=1 and ready=0.
  - The arbiter never asserts wren while wrfull=1. This matches the FIFO's internal wren & ~wrfull gating, so no write is silently discarded.
- wren, wrdata and req_ready are combinational from registered state plus req_valid/wrfull. Latency from request to first write is 1 cycle (the IDLE cycle).
- Fairness: with all producers continuously valid, grants rotate 0,1,2,3,0,... and each burst is exactly BURST_LEN beats. No producer waits more than (NUM_REQ-1) bursts.
- wrdata is 0 whenever wren=0.
- beat_cnt width is ceil(log2(BURST_LEN))+1. Compares are unsigned.

Optional Feature:
- Macro: FIFO_WR_ARB_TAG_EN.
- Defined: wrdata[DATA_W-1 -: ID_W] is replaced by grant_id on every written beat. Only the low DATA_W-ID_W payload bits pass through, so the read side can demultiplex by source.
- Undefined: wrdata is the producer's full DATA_W bits, unmodified.

Test Plan:
- Reset / single producer: assert rst mid-operation, then release. Producer 2 holds valid for 6 beats (D0..D5) with wrfull=0 -> grant_id=2. wren high for beats D0..D3, then 1 idle cycle, then a re-grant to 2 for D4..D5. Total 6 writes, in order.
- All four producers continuously valid -> grant order 0,1,2,3,0. Each burst is exactly 4 wren pulses separated by 1 bubble cycle. The FIFO sees 20 writes in 25 cycles.
- Backpressure: wrfull=1 for 3 cycles mid-burst on beat 2 -> wren=0 and req_ready=0 for those 3 cycles. beat_cnt holds at 2. The burst completes with beats 2,3 after wrfull drops, with no loss or duplication.
- Early release: producer 1 drops valid after 2 beats while producer 3 is valid -> FSM returns to IDLE with no write that cycle, grant passes to 3, and rr_ptr=1.
- Async reset mid-burst: rst pulse on beat 1 -> wren, busy, req_ready and grant_id go to 0 without a clock edge. After release, the first grant goes to producer 0 if all are valid.
- With FIFO_WR_ARB_TAG_EN defined and DATA_W=140: producer 3 writes all-zero data -> wrdata[139:138]=2'b11 and wrdata[137:0]=0.
